// File: rtl/rx_soh_pkg.sv
// Shared constants, state encoding and helpers for the STM-1 RX MSOH monitor.
package rx_soh_pkg;

    localparam int CNT_W     = 12;
    localparam int FRAME_LEN = 2430;
    localparam int ROW_LEN   = 270;

    localparam logic [CNT_W-1:0] FRAME_LAST = 12'd2429;
    localparam logic [CNT_W-1:0] B2_POS     = 12'd1080;
    localparam logic [CNT_W-1:0] K1_POS     = 12'd1083;
    localparam logic [CNT_W-1:0] K2_POS     = 12'd1086;

    // MS-AIS set/clear persistence in frames
    localparam logic [1:0] AIS_PERSIST = 2'd3;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FIRST = 2'd1,
        LOCK  = 2'd2
    } soh_state_t;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/rx_b2_cmp.sv
// B2 byte comparator: XOR each received B2 byte against its BIP-24 reference
// byte, popcount the difference and sum over the three B2 bytes.
import rx_soh_pkg::*;

module rx_b2_cmp (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic [7:0] ref_byte,
    input  logic       en,
    input  logic       start,
    input  logic       last,
    output logic [4:0] sum,
    output logic       done
);

    logic [3:0] pc;

    assign pc = popcnt8(data ^ ref_byte);

    // Accumulate per-byte mismatch counts; done follows the third byte by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            done <= 1'b0;
        end else begin
            done <= en & last;
            if (en) sum <= start ? {1'b0, pc} : sum + {1'b0, pc};
        end
    end

endmodule

// File: rtl/rx_msoh_mon.sv
// STM-1 RX multiplex-section overhead monitor: frame position tracking,
// B2 BIP-24 check with saturating error count, K1/K2 persistence acceptance.
// Optional MS-AIS detection on K2[2:0] is enabled by defining RX_MSAIS_DET_EN.
import rx_soh_pkg::*;

module rx_msoh_mon #(
    parameter int KPERSIST = 3,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk19,
    input  logic                rst19,
    input  logic [7:0]          pdi,
    input  logic                sofi,
    input  logic [23:0]         b2dat,
    input  logic                b2vld,
    input  logic                clr_cnt,
    output logic                frm_lock,
    output logic [4:0]          b2err_bits,
    output logic                b2err_vld,
    output logic [ERRCNT_W-1:0] b2err_acc,
    output logic [7:0]          k1_acc,
    output logic [7:0]          k2_acc,
    output logic                kchg,
    output logic                msais
);

    localparam int             PC_W = $clog2(KPERSIST + 1);
    localparam logic [PC_W-1:0] KP  = PC_W'(KPERSIST);

    soh_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             active, realign;
    logic             at_b2a, at_b2b, at_b2c, at_k1, at_k2;

    // Byte positions only count while aligned and not being realigned this byte
    always_comb begin
        active  = (state == FIRST) || (state == LOCK);
        realign = active && sofi && (cnt != '0);
        at_b2a  = active && !realign && (cnt == B2_POS);
        at_b2b  = active && !realign && (cnt == B2_POS + 12'd1);
        at_b2c  = active && !realign && (cnt == B2_POS + 12'd2);
        at_k1   = active && !realign && (cnt == K1_POS);
        at_k2   = active && !realign && (cnt == K2_POS);
    end

    // Frame alignment FSM with byte counter; lock is decided on the byte after the wrap
    always_ff @(posedge clk19 or negedge rst19) begin
        if (!rst19) begin
            state    <= HUNT;
            cnt      <= '0;
            frm_lock <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (sofi) begin
                        cnt   <= 12'd1;
                        state <= FIRST;
                    end
                end
                FIRST, LOCK: begin
                    if (realign) begin
                        cnt      <= 12'd1;
                        state    <= FIRST;
                        frm_lock <= 1'b0;
                    end else if (cnt == '0) begin
                        if (sofi) begin
                            cnt      <= 12'd1;
                            state    <= LOCK;
                            frm_lock <= 1'b1;
                        end else begin
                            state    <= HUNT;
                            frm_lock <= 1'b0;
                        end
                    end else if (cnt == FRAME_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: begin
                    state    <= HUNT;
                    cnt      <= '0;
                    frm_lock <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- B2
    logic [23:0] b2ref;
    logic        ref_ok, b2_on;
    logic        cmp_start, cmp_mid, cmp_last, cmp_en;
    logic [7:0]  ref_byte;
    logic [4:0]  cmp_sum;
    logic        cmp_done;

    // A compare is armed at the first B2 byte and must see the next two in sequence
    always_comb begin
        cmp_start = (state == LOCK) && ref_ok && at_b2a;
        cmp_mid   = (state == LOCK) && b2_on && at_b2b;
        cmp_last  = (state == LOCK) && b2_on && at_b2c;
        cmp_en    = cmp_start | cmp_mid | cmp_last;
        ref_byte  = cmp_start ? b2ref[23:16] : (cmp_mid ? b2ref[15:8] : b2ref[7:0]);
    end

    // Reference capture; a fresh b2vld wins over the end-of-compare invalidation
    always_ff @(posedge clk19 or negedge rst19) begin
        if (!rst19) begin
            b2ref  <= '0;
            ref_ok <= 1'b0;
            b2_on  <= 1'b0;
        end else begin
            b2_on <= cmp_start | cmp_mid;
            if (b2vld) begin
                b2ref  <= b2dat;
                ref_ok <= 1'b1;
            end else if (at_b2c) begin
                ref_ok <= 1'b0;
            end
        end
    end

    rx_b2_cmp u_b2_cmp (
        .clk      (clk19),
        .rst_n    (rst19),
        .data     (pdi),
        .ref_byte (ref_byte),
        .en       (cmp_en),
        .start    (cmp_start),
        .last     (cmp_last),
        .sum      (cmp_sum),
        .done     (cmp_done)
    );

    logic [ERRCNT_W:0] acc_sum;

    assign acc_sum = {1'b0, b2err_acc} + (ERRCNT_W + 1)'(b2err_bits);

    // Error strobe two bytes after the last B2 byte, then saturating accumulate
    always_ff @(posedge clk19 or negedge rst19) begin
        if (!rst19) begin
            b2err_vld  <= 1'b0;
            b2err_bits <= '0;
            b2err_acc  <= '0;
        end else begin
            b2err_vld <= cmp_done;
            if (cmp_done) b2err_bits <= cmp_sum;
            if (clr_cnt)
                b2err_acc <= b2err_vld ? ERRCNT_W'(b2err_bits) : '0;
            else if (b2err_vld)
                b2err_acc <= acc_sum[ERRCNT_W] ? '1 : acc_sum[ERRCNT_W-1:0];
        end
    end

    // ---------------------------------------------------------------- K1/K2
    logic [7:0]      k1_cap;
    logic [15:0]     cand, prev_cand;
    logic            prev_vld;
    logic [PC_W-1:0] pcnt, pcnt_nxt;

    // Persistence count for the candidate captured this byte
    always_comb begin
        cand = {k1_cap, pdi};
        if (prev_vld && (cand == prev_cand))
            pcnt_nxt = (pcnt >= KP) ? KP : pcnt + 1'b1;
        else
            pcnt_nxt = PC_W'(1);
    end

    // Candidate capture and acceptance; history is dropped while hunting
    always_ff @(posedge clk19 or negedge rst19) begin
        if (!rst19) begin
            k1_cap    <= '0;
            prev_cand <= '0;
            prev_vld  <= 1'b0;
            pcnt      <= '0;
            k1_acc    <= '0;
            k2_acc    <= '0;
            kchg      <= 1'b0;
        end else begin
            kchg <= 1'b0;
            if (at_k1) k1_cap <= pdi;
            if (state == HUNT) begin
                prev_cand <= '0;
                prev_vld  <= 1'b0;
                pcnt      <= '0;
            end else if (at_k2) begin
                prev_cand <= cand;
                prev_vld  <= 1'b1;
                pcnt      <= pcnt_nxt;
                if ((pcnt_nxt == KP) && (cand != {k1_acc, k2_acc})) begin
                    k1_acc <= cand[15:8];
                    k2_acc <= cand[7:0];
                    kchg   <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- MS-AIS
`ifdef RX_MSAIS_DET_EN
    logic [1:0] ais_on, ais_off, ais_on_nxt, ais_off_nxt;

    always_comb begin
        ais_on_nxt  = (ais_on  == AIS_PERSIST) ? AIS_PERSIST : ais_on  + 2'd1;
        ais_off_nxt = (ais_off == AIS_PERSIST) ? AIS_PERSIST : ais_off + 2'd1;
    end

    // Set/clear after three consecutive captured frames of the same K2[2:0] class
    always_ff @(posedge clk19 or negedge rst19) begin
        if (!rst19) begin
            ais_on  <= '0;
            ais_off <= '0;
            msais   <= 1'b0;
        end else if (state == HUNT) begin
            ais_on  <= '0;
            ais_off <= '0;
            msais   <= 1'b0;
        end else if (at_k2) begin
            if (pdi[2:0] == 3'b111) begin
                ais_off <= '0;
                ais_on  <= ais_on_nxt;
                if (ais_on_nxt == AIS_PERSIST) msais <= 1'b1;
            end else begin
                ais_on  <= '0;
                ais_off <= ais_off_nxt;
                if (ais_off_nxt == AIS_PERSIST) msais <= 1'b0;
            end
        end
    end
`else
    assign msais = 1'b0;
`endif

endmodule

// File: tb/tb_rx_msoh_mon.sv
// Frame-level bench for rx_msoh_mon: a table of frame records drives the byte
// stream, B2 results go through a scoreboard queue checked by a monitor.
module tb_rx_msoh_mon;

    localparam int EW = 6;

    logic          clk19 = 1'b0;
    logic          rst19;
    logic [7:0]    pdi;
    logic          sofi;
    logic [23:0]   b2dat;
    logic          b2vld;
    logic          clr_cnt;
    logic          frm_lock;
    logic [4:0]    b2err_bits;
    logic          b2err_vld;
    logic [EW-1:0] b2err_acc;
    logic [7:0]    k1_acc, k2_acc;
    logic          kchg;
    logic          msais;

    rx_msoh_mon #(.KPERSIST(3), .ERRCNT_W(EW)) dut (
        .clk19      (clk19),
        .rst19      (rst19),
        .pdi        (pdi),
        .sofi       (sofi),
        .b2dat      (b2dat),
        .b2vld      (b2vld),
        .clr_cnt    (clr_cnt),
        .frm_lock   (frm_lock),
        .b2err_bits (b2err_bits),
        .b2err_vld  (b2err_vld),
        .b2err_acc  (b2err_acc),
        .k1_acc     (k1_acc),
        .k2_acc     (k2_acc),
        .kchg       (kchg),
        .msais      (msais)
    );

    always #25 clk19 = ~clk19;

    typedef struct {
        int          gap;
        bit          sofi_en;
        logic [23:0] b2b;
        logic [15:0] k;
        int          clr_at;
        bit          exp_lock;
        bit          exp_b2v;
        int          exp_bits;
        int          exp_acc;
        int          exp_kchg;
        logic [15:0] exp_k;
        bit          exp_ais;
    } frm_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_j = -1;
    int kchg_cnt = 0;
    int exp_q[$];
    bit ais_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (byte %0d)", name, act, exp, cur_j);
        end
    endtask

    function automatic frm_t mk(input int gap, input bit s, input logic [23:0] b2b,
                                input logic [15:0] k, input int clr, input bit lk,
                                input bit bv, input int bits, input int acc,
                                input int kc, input logic [15:0] ka, input bit ais);
        frm_t r;
        r.gap = gap; r.sofi_en = s; r.b2b = b2b; r.k = k; r.clr_at = clr;
        r.exp_lock = lk; r.exp_b2v = bv; r.exp_bits = bits; r.exp_acc = acc;
        r.exp_kchg = kc; r.exp_k = ka; r.exp_ais = ais;
        return r;
    endfunction

    // Scoreboard side: every strobe must match the oldest queued expectation
    always @(negedge clk19) begin
        if (rst19 && b2err_vld) begin
            if (exp_q.size() == 0) begin
                chk("b2err_vld_unexpected", 32'd1, 32'd0);
            end else begin
                chk("b2err_bits", 32'(b2err_bits), 32'(exp_q.pop_front()));
                chk("b2err_vld_timing", 32'(cur_j), 32'd1084);
            end
        end
        if (rst19 && kchg) kchg_cnt++;
    end

    task automatic run_frame(input frm_t r, input int fi);
        for (int g = 0; g < r.gap; g++) begin
            @(posedge clk19); #1;
            cur_j = -1; sofi = 1'b0; pdi = 8'h00; b2vld = 1'b0; clr_cnt = 1'b0;
        end
        kchg_cnt = 0;
        for (int j = 0; j < 2430; j++) begin
            @(posedge clk19); #1;
            cur_j   = j;
            sofi    = (j == 0) && r.sofi_en;
            b2vld   = (j == 10) || (j == 11);
            clr_cnt = (j == r.clr_at);
            case (j)
                1080:    pdi = r.b2b[23:16];
                1081:    pdi = r.b2b[15:8];
                1082:    pdi = r.b2b[7:0];
                1083:    pdi = r.k[15:8];
                1086:    pdi = r.k[7:0];
                default: pdi = 8'h00;
            endcase
            if (j == 1082 && r.exp_b2v) exp_q.push_back(r.exp_bits);
            @(negedge clk19);
            if (fi == 1 && j <= 1) chk("lock_rise", 32'(frm_lock), 32'(j));
            if (j == 100) chk($sformatf("frm_lock f%0d", fi), 32'(frm_lock), 32'(r.exp_lock));
            if (j == 2429) begin
                chk($sformatf("b2_missing f%0d", fi), 32'(exp_q.size()), 32'd0);
                chk($sformatf("b2err_acc f%0d", fi), 32'(b2err_acc), 32'(r.exp_acc));
                chk($sformatf("kchg_cnt f%0d", fi), 32'(kchg_cnt), 32'(r.exp_kchg));
                chk($sformatf("k_acc f%0d", fi), 32'({k1_acc, k2_acc}), 32'(r.exp_k));
                chk($sformatf("msais f%0d", fi), 32'(msais), 32'(r.exp_ais & ais_en));
            end
        end
    endtask

    frm_t tbl[27];

    initial begin
`ifdef RX_MSAIS_DET_EN
        ais_en = 1'b1;
`else
        ais_en = 1'b0;
`endif
        //            gap s  B2 bytes     K1K2      clr  lk bv bits acc kc exp_k     ais
        tbl[0]  = mk(0, 1, 24'hA5A5A5, 16'h0000, -1,   0, 0, 0,   0,  0, 16'h0000, 0);
        tbl[1]  = mk(0, 1, 24'hA5A5A5, 16'h0000, -1,   1, 1, 0,   0,  0, 16'h0000, 0);
        tbl[2]  = mk(0, 1, 24'hA5A5A5, 16'h0000, -1,   1, 1, 0,   0,  0, 16'h0000, 0);
        tbl[3]  = mk(0, 1, 24'hA4A55A, 16'h0000, -1,   1, 1, 9,   9,  0, 16'h0000, 0);
        tbl[4]  = mk(0, 1, 24'hA4A55A, 16'h0000, -1,   1, 1, 9,  18,  0, 16'h0000, 0);
        tbl[5]  = mk(0, 1, 24'hA5A5A5, 16'h1234, -1,   1, 1, 0,  18,  0, 16'h0000, 0);
        tbl[6]  = mk(0, 1, 24'hA5A5A5, 16'h1234, -1,   1, 1, 0,  18,  0, 16'h0000, 0);
        tbl[7]  = mk(0, 1, 24'hA5A5A5, 16'h1234, -1,   1, 1, 0,  18,  1, 16'h1234, 0);
        tbl[8]  = mk(0, 1, 24'hA5A5A5, 16'h5678, -1,   1, 1, 0,  18,  0, 16'h1234, 0);
        tbl[9]  = mk(0, 1, 24'hA5A5A5, 16'h1234, -1,   1, 1, 0,  18,  0, 16'h1234, 0);
        tbl[10] = mk(0, 1, 24'hA5A5A5, 16'h5678, -1,   1, 1, 0,  18,  0, 16'h1234, 0);
        tbl[11] = mk(5, 1, 24'hA5A5A5, 16'h1234, -1,   0, 0, 0,  18,  0, 16'h1234, 0);
        tbl[12] = mk(0, 1, 24'hA5A5A5, 16'h1234, -1,   1, 1, 0,  18,  0, 16'h1234, 0);
        tbl[13] = mk(0, 0, 24'hA5A5A5, 16'h1234, -1,   0, 0, 0,  18,  0, 16'h1234, 0);
        tbl[14] = mk(0, 1, 24'hA5A5A5, 16'h1234, -1,   0, 0, 0,  18,  0, 16'h1234, 0);
        tbl[15] = mk(0, 1, 24'hA5A5A5, 16'h1234, -1,   1, 1, 0,  18,  0, 16'h1234, 0);
        tbl[16] = mk(0, 1, 24'h5A5A5A, 16'h1234, -1,   1, 1, 24, 42,  0, 16'h1234, 0);
        tbl[17] = mk(0, 1, 24'h5A5A5A, 16'h1234, -1,   1, 1, 24, 63,  0, 16'h1234, 0);
        tbl[18] = mk(0, 1, 24'h5A5A5A, 16'h1234, -1,   1, 1, 24, 63,  0, 16'h1234, 0);
        tbl[19] = mk(0, 1, 24'hA4A6A5, 16'h1234, 1084, 1, 1, 3,   3,  0, 16'h1234, 0);
        tbl[20] = mk(0, 1, 24'hA4A55A, 16'h1234, 50,   1, 1, 9,   9,  0, 16'h1234, 0);
        tbl[21] = mk(0, 1, 24'hA5A5A5, 16'h0007, -1,   1, 1, 0,   9,  0, 16'h1234, 0);
        tbl[22] = mk(0, 1, 24'hA5A5A5, 16'h0007, -1,   1, 1, 0,   9,  0, 16'h1234, 0);
        tbl[23] = mk(0, 1, 24'hA5A5A5, 16'h0007, -1,   1, 1, 0,   9,  1, 16'h0007, 1);
        tbl[24] = mk(0, 1, 24'hA5A5A5, 16'h0000, -1,   1, 1, 0,   9,  0, 16'h0007, 1);
        tbl[25] = mk(0, 1, 24'hA5A5A5, 16'h0000, -1,   1, 1, 0,   9,  0, 16'h0007, 1);
        tbl[26] = mk(0, 1, 24'hA5A5A5, 16'h0000, -1,   1, 1, 0,   9,  1, 16'h0000, 0);

        rst19 = 1'b0; pdi = 8'h00; sofi = 1'b0; b2dat = 24'hA5A5A5;
        b2vld = 1'b0; clr_cnt = 1'b0;
        repeat (4) @(posedge clk19);
        @(negedge clk19);
        chk("rst frm_lock", 32'(frm_lock), 32'd0);
        chk("rst b2err_vld", 32'(b2err_vld), 32'd0);
        chk("rst b2err_bits", 32'(b2err_bits), 32'd0);
        chk("rst b2err_acc", 32'(b2err_acc), 32'd0);
        chk("rst k_acc", 32'({k1_acc, k2_acc}), 32'd0);
        chk("rst kchg", 32'(kchg), 32'd0);
        chk("rst msais", 32'(msais), 32'd0);
        @(posedge clk19); #1 rst19 = 1'b1;
        repeat (3) @(posedge clk19);

        for (int f = 0; f < 27; f++) run_frame(tbl[f], f);

        // Reset asserted in the middle of a locked frame
        for (int j = 0; j < 500; j++) begin
            @(posedge clk19); #1;
            cur_j = j; sofi = (j == 0); pdi = 8'h00; b2vld = 1'b0; clr_cnt = 1'b0;
        end
        @(negedge clk19);
        chk("pre_rst frm_lock", 32'(frm_lock), 32'd1);
        #5 rst19 = 1'b0;
        #2;
        chk("mid_rst frm_lock", 32'(frm_lock), 32'd0);
        chk("mid_rst b2err_acc", 32'(b2err_acc), 32'd0);
        chk("mid_rst k_acc", 32'({k1_acc, k2_acc}), 32'd0);
        chk("mid_rst b2err_bits", 32'(b2err_bits), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_msoh_mon.md
Name: rx_msoh_mon

Overview:
- Byte-domain monitor directly downstream of the STM-1 serial-to-parallel stage.
- Consumes descrambled bytes, frame start and the per-frame computed BIP-24 from that stage.
- Tracks frame position, checks received B2 bytes against the computed BIP-24, counts B2 bit errors, and performs 3-frame persistence acceptance of K1/K2.
- Feeds the MS alarm/APS logic.

Parameters:
- FRAME_LEN, 2430, bytes per STM-1 frame (9 rows x 270).
- ROW_LEN, 270, bytes per row.
- KPERSIST, 3, consecutive identical frames needed to accept K1/K2.
- ERRCNT_W, 16, width of the accumulated B2 error counter.

Ports:
- clk19  in  1  19.44 MHz byte clock.
- rst19  in  1  reset, asynchronous, active-low.
- pdi  in  8  descrambled byte, bit 7 = first received bit.
- sofi  in  1  high with the first A1 byte (row 1, col 1) on pdi.
- b2dat  in  24  BIP-24 computed over the previous frame.
- b2vld  in  1  b2dat valid, held stable for at least 2 clk19 cycles, once per frame, before row 5.
- clr_cnt  in  1  synchronous clear of b2err_acc.
- frm_lock  out  1  frame position tracked.
- b2err_bits  out  5  mismatched B2 bits this frame (0..24).
- b2err_vld  out  1  one-cycle strobe qualifying b2err_bits.
- b2err_acc  out  ERRCNT_W  saturating accumulated B2 error bits.
- k1_acc  out  8  accepted K1.
- k2_acc  out  8  accepted K2.
- kchg  out  1  one-cycle pulse when k1_acc/k2_acc update.
- msais  out  1  MS-AIS detected (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, state HUNT, byte counter 0, B2 reference invalid, persistence count 0.
- Byte counter runs 0..FRAME_LEN-1. Byte index 0 is the byte with sofi.
- Fixed positions:
  - B2 at indexes 1080, 1081, 1082 (row 5, cols 1-3).
  - K1 at 1083.
  - K2 at 1086.
- FSM:
  - HUNT: on sofi, counter := 1 next cycle, go FIRST.
  - FIRST: first frame after alignment. B2 compare suppressed; K capture active. At index FRAME_LEN-1, go LOCK if sofi is present on the next byte, else HUNT.
  - LOCK: frm_lock=1.
  - In FIRST or LOCK, sofi at index != 0 realigns the counter (sofi byte = index 0), goes FIRST, frm_lock=0.
  - In FIRST or LOCK, wrap to 0 without sofi goes HUNT.
- B2 reference: any cycle with b2vld=1 loads b2dat into b2ref and sets ref_ok.
- B2 compare, LOCK only and ref_ok=1:
  - XOR pdi with b2ref[23:16], [15:8], [7:0] at 1080/1081/1082 respectively.
  - Popcount is summed.
  - b2err_vld pulses, and b2err_bits is valid, exactly 2 cycles after index 1082.
  - ref_ok cleared at index 1082.
  - No pulse if the condition is false at index 1080.
- b2err_acc:
  - On b2err_vld, adds b2err_bits, saturating at 2^ERRCNT_W-1.
  - clr_cnt alone: acc := 0.
  - clr_cnt together with b2err_vld: acc := b2err_bits.
- K1/K2, FIRST or LOCK:
  - Candidate {K1,K2} is captured at 1086.
  - If the candidate equals the previous frame's candidate, pcnt := min(pcnt+1, KPERSIST); else pcnt := 1.
  - When pcnt reaches KPERSIST and the candidate differs from {k1_acc,k2_acc}: update both and pulse kchg 1 cycle after the capture.
  - Entering HUNT clears the previous candidate and pcnt; accepted values are held.
- Reset asserted mid-frame returns everything to reset values immediately.

Optional Feature:
- Macro: RX_MSAIS_DET_EN.
- Defined:
  - msais sets after 3 consecutive captured frames with K2[2:0]=3'b111.
  - msais clears after 3 consecutive frames with K2[2:0]!=3'b111.
  - msais is forced to 0 in HUNT.
- Undefined: msais tied 0; port retained.

Decomposition:
- Package rx_soh_pkg holds:
  - FRAME_LEN, ROW_LEN.
  - B2_POS=1080, K1_POS=1083, K2_POS=1086.
  - FSM state encodings HUNT/FIRST/LOCK.
- Sub-module rx_b2_cmp: per-byte XOR+popcount plus 3-byte sum register, output 5 bits.

Test Plan:
- Sofi every 2430 cycles, b2dat=24'hA5A5A5, B2 bytes A5,A5,A5:
  - frm_lock rises at the start of the 2nd frame.
  - b2err_vld from the 2nd frame with b2err_bits=0; acc stays 0.
- Same setup, B2 bytes A4,A5,5A: b2err_bits=1+0+8=9; acc increments by 9 each frame.
- K1/K2 = 8'h12/8'h34 for 3 frames: kchg pulse once after the 3rd capture with k1_acc=12, k2_acc=34. Alternating values: no kchg.
- Sofi displaced by +5 bytes in LOCK: frm_lock=0, no b2err_vld for that frame, re-lock next frame. Sofi missing: HUNT.
- acc preloaded to 16'hFFF0, errors 24/frame: saturates at FFFF. clr_cnt with b2err_vld (bits=3): acc=3.
- With RX_MSAIS_DET_EN, K2=8'h07 for 3 frames: msais=1; K2=8'h00 for 3 frames: msais=0. Without the macro: msais stays 0.
